// File: rtl/larpix_pkg.sv
// Shared packet layout, constants and parity helper for the LArPix config link.
package larpix_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    DATA      = 2'd1,
    CFG_WRITE = 2'd2,
    CFG_READ  = 2'd3
  } packet_declare_t;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LOAD      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam int DECLARE_LSB = 0;
  localparam int DECLARE_W   = 2;
  localparam int CHIP_LSB    = 2;
  localparam int CHIP_W      = 8;
  localparam int ADDR_LSB    = 10;
  localparam int ADDR_W      = 8;
  localparam int DATA_LSB    = 18;
  localparam int DATA_W      = 8;
  localparam int MAGIC_LSB   = 26;
  localparam int MAGIC_W     = 32;
  localparam int RSVD_LSB    = 58;
  localparam int RSVD_W      = 4;
  localparam int MARKER_BIT  = 62;
  localparam int PARITY_BIT  = 63;

  localparam logic [31:0] MAGIC_NUMBER = 32'h89504E47;
  localparam logic [7:0]  GLOBAL_ID    = 8'hFF;
  localparam logic [3:0]  BUSY_TIMEOUT = 4'd15;

  // Parity bit that makes the XOR of all 64 bits equal to one.
  function automatic logic odd_parity(input logic [62:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/larpix_config_responder_reply_fifo.sv
// Small synchronous FIFO holding reply packets until the TX FSM can send them.
module reply_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy update; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    dout      = mem_q[rd_ptr_q];
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && !empty;
    wr_ptr_d  = do_push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/larpix_config_responder.sv
// Chip-side config responder: decodes config packets, owns the register map
// and hands reply packets to uart_tx through a small FIFO and TX FSM.
module larpix_config_responder #(
  parameter int               WIDTH           = 64,
  parameter int               WORDWIDTH       = 8,
  parameter int               REGNUM          = 256,
  parameter int               FIFO_DEPTH      = 2,
  parameter int               CHIP_ID_ADDR    = 122,
  parameter logic [7:0]       DEFAULT_CHIP_ID = 8'd1,
  parameter logic [7:0]       GLOBAL_ID       = 8'd255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_parity_error,
  output logic [WIDTH-1:0]            tx_data,
  output logic                        ld_tx_data,
  input  logic                        tx_busy,
  output logic [REGNUM*WORDWIDTH-1:0] config_bits,
  output logic [7:0]                  chip_id,
  output logic [7:0]                  drop_count
);

  import larpix_pkg::*;

  logic [WORDWIDTH-1:0] regs_q [REGNUM];
  logic [7:0]           drop_count_q, drop_count_d;
  logic [WIDTH-1:0]     tx_data_q;
  logic                 ld_tx_q;
  tx_state_t            state_q;
  logic [3:0]           timer_q;

  packet_declare_t      declare_s;
  logic [7:0]           chip_s, addr_s, data_s, rd_data_s, chip_id_s;
  logic [31:0]          magic_s;
  logic                 addr_ok_s, accept_s, reject_s, wr_en_s;
  logic                 push_s, pop_s, fifo_drop_s;
  logic [WIDTH-1:0]     reply_s, fifo_dout_s;
  logic                 fifo_full_s, fifo_empty_s;

  // Addresses beyond the map only exist when the map is smaller than the address field.
  if (REGNUM < 256) begin : g_addr_chk
    assign addr_ok_s = (32'(addr_s) < REGNUM);
  end else begin : g_addr_all
    assign addr_ok_s = 1'b1;
  end

  assign chip_id_s = regs_q[CHIP_ID_ADDR];

  // Packet decode and reply framing, all in the rx_valid cycle.
  always_comb begin
    declare_s = packet_declare_t'(rx_data[DECLARE_LSB +: DECLARE_W]);
    chip_s    = rx_data[CHIP_LSB +: CHIP_W];
    addr_s    = rx_data[ADDR_LSB +: ADDR_W];
    data_s    = rx_data[DATA_LSB +: DATA_W];
    magic_s   = rx_data[MAGIC_LSB +: MAGIC_W];
    rd_data_s = addr_ok_s ? regs_q[addr_s] : 8'h00;
    accept_s  = 1'b0;
    reject_s  = 1'b0;
    if (rx_valid) begin
      if (rx_parity_error) begin
        reject_s = 1'b1;
      end else begin
        case (declare_s)
          CFG_WRITE, CFG_READ: begin
            if (magic_s != MAGIC_NUMBER) begin
              reject_s = 1'b1;
            end else if (chip_s == chip_id_s || chip_s == GLOBAL_ID) begin
              accept_s = 1'b1;
            end else begin
              accept_s = 1'b0;
            end
          end
          default: reject_s = 1'b1;
        endcase
      end
    end else begin
      reject_s = 1'b0;
    end

    reply_s                         = rx_data;
    reply_s[CHIP_LSB +: CHIP_W]     = chip_id_s;
    reply_s[RSVD_LSB +: RSVD_W]     = 4'h0;
    reply_s[MARKER_BIT]             = 1'b1;
    if (declare_s == CFG_READ) begin
      reply_s[DATA_LSB +: DATA_W] = rd_data_s;
    end else begin
      reply_s[DATA_LSB +: DATA_W] = data_s;
    end
    reply_s[PARITY_BIT] = odd_parity(reply_s[62:0]);

    wr_en_s     = accept_s && (declare_s == CFG_WRITE) && addr_ok_s;
    pop_s       = (state_q == TX_IDLE) && !fifo_empty_s;
    push_s      = accept_s && (!fifo_full_s || pop_s);
    fifo_drop_s = accept_s && fifo_full_s && !pop_s;

    if ((reject_s || fifo_drop_s) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Register map and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < REGNUM; k++) begin
        regs_q[k] <= (k == CHIP_ID_ADDR) ? DEFAULT_CHIP_ID : '0;
      end
      drop_count_q <= 8'h00;
    end else begin
      if (wr_en_s) regs_q[addr_s] <= data_s;
      drop_count_q <= drop_count_d;
    end
  end

  reply_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_reply_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (reply_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // TX handshake FSM; a silent uart_tx is abandoned after 16 cycles in WAIT_BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      ld_tx_q   <= 1'b0;
      timer_q   <= 4'd0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          ld_tx_q <= 1'b0;
          if (!fifo_empty_s) begin
            tx_data_q <= fifo_dout_s;
            ld_tx_q   <= 1'b1;
            state_q   <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          ld_tx_q <= 1'b0;
          timer_q <= 4'd0;
          state_q <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          ld_tx_q <= 1'b0;
          if (tx_busy) begin
            state_q <= TX_WAIT_DONE;
          end else if (timer_q == BUSY_TIMEOUT) begin
            state_q <= TX_IDLE;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        TX_WAIT_DONE: begin
          ld_tx_q <= 1'b0;
          if (!tx_busy) state_q <= TX_IDLE;
        end
        default: begin
          ld_tx_q <= 1'b0;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // Flatten the register map onto config_bits.
  always_comb begin
    config_bits = '0;
    for (int k = 0; k < REGNUM; k++) begin
      config_bits[k*WORDWIDTH +: WORDWIDTH] = regs_q[k];
    end
  end

  assign tx_data    = tx_data_q;
  assign ld_tx_data = ld_tx_q;
  assign chip_id    = chip_id_s;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_larpix_config_responder.sv
// Directed bench for larpix_config_responder with a reply scoreboard and a uart_tx busy model.
module tb_larpix_config_responder;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   rx_data = 64'h0;
  logic          rx_valid = 1'b0;
  logic          rx_parity_error = 1'b0;
  logic [63:0]   tx_data;
  logic          ld_tx_data;
  logic          tx_busy = 1'b0;
  logic [2047:0] config_bits;
  logic [7:0]    chip_id;
  logic [7:0]    drop_count;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q [$];
  logic        hold_busy = 1'b0;
  int          busy_cnt = 0;

  larpix_config_responder dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_parity_error (rx_parity_error),
    .tx_data         (tx_data),
    .ld_tx_data      (ld_tx_data),
    .tx_busy         (tx_busy),
    .config_bits     (config_bits),
    .chip_id         (chip_id),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] dec, input logic [7:0] chip,
                                     input logic [7:0] addr, input logic [7:0] data,
                                     input logic [31:0] magic, input logic marker);
    logic [63:0] p;
    p        = 64'h0;
    p[1:0]   = dec;
    p[9:2]   = chip;
    p[17:10] = addr;
    p[25:18] = data;
    p[57:26] = magic;
    p[62]    = marker;
    p[63]    = ~(^p[62:0]);
    return p;
  endfunction

  function automatic logic [7:0] cfg_byte(input int k);
    return config_bits[k*8 +: 8];
  endfunction

  // Caller is at a negedge; returns at the next negedge so calls can be chained back-to-back.
  task automatic send(input logic [63:0] p, input logic pe);
    rx_data         = p;
    rx_valid        = 1'b1;
    rx_parity_error = pe;
    @(negedge clk);
    rx_valid        = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !tx_busy) break;
      @(negedge clk);
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (30) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // uart_tx stand-in: busy for a few cycles after each load, or held by the stimulus.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) busy_cnt = 0;
      else if (ld_tx_data) busy_cnt = 6;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = hold_busy || (busy_cnt > 0);
    end
  end

  // Scoreboard monitor: every load strobe must match the oldest expected reply.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && ld_tx_data) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_reply actual=%h required=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("reply", tx_data, e);
          check("reply_odd_parity", 64'(^tx_data), 64'd1);
        end
      end
    end
  end

  initial begin
    logic [63:0] p;
    int          nbad;
    localparam logic [31:0] MG = 32'h89504E47;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset while a reply is queued
    send(mk(2'd2, 8'd1, 8'd10, 8'h55, MG, 1'b0), 1'b0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_ld_low", 64'(ld_tx_data), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_chip_id", 64'(chip_id), 64'd1);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_tx_data", tx_data, 64'h0);
    nbad = 0;
    for (int k = 0; k < 256; k++) begin
      if (cfg_byte(k) !== ((k == 122) ? 8'd1 : 8'd0)) nbad++;
    end
    check("rst_cfg_bad_bytes", 64'(nbad), 64'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 2: write with latency check
    exp_q.push_back(mk(2'd2, 8'd1, 8'd10, 8'hA5, MG, 1'b1));
    rx_data  = mk(2'd2, 8'd1, 8'd10, 8'hA5, MG, 1'b0);
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ld_at_n1", 64'(ld_tx_data), 64'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ld_at_n2", 64'(ld_tx_data), 64'd1);
    @(negedge clk);
    check("reg10_written", 64'(cfg_byte(10)), 64'hA5);
    drain("drain_write");

    // 3: read back; reserved bits and data field of the request are replaced
    p        = mk(2'd3, 8'd1, 8'd10, 8'h3C, MG, 1'b0);
    p[61:58] = 4'hA;
    p[63]    = ~(^p[62:0]);
    exp_q.push_back(mk(2'd3, 8'd1, 8'd10, 8'hA5, MG, 1'b1));
    send(p, 1'b0);
    drain("drain_read");

    // 4: rejected packets
    send(mk(2'd2, 8'd1, 8'd10, 8'h33, MG, 1'b0), 1'b1);
    send(mk(2'd2, 8'd1, 8'd10, 8'h44, 32'h0, 1'b0), 1'b0);
    drain("drain_rejects");
    check("reg10_unchanged", 64'(cfg_byte(10)), 64'hA5);
    check("drop_count_two", 64'(drop_count), 64'd2);

    // 5: broadcast chip-id change, then old and new id
    exp_q.push_back(mk(2'd2, 8'd1, 8'd122, 8'd7, MG, 1'b1));
    send(mk(2'd2, 8'd255, 8'd122, 8'd7, MG, 1'b0), 1'b0);
    drain("drain_bcast");
    check("chip_id_seven", 64'(chip_id), 64'd7);
    send(mk(2'd3, 8'd1, 8'd10, 8'h00, MG, 1'b0), 1'b0);
    drain("drain_ignored");
    exp_q.push_back(mk(2'd3, 8'd7, 8'd10, 8'hA5, MG, 1'b1));
    send(mk(2'd3, 8'd7, 8'd10, 8'h00, MG, 1'b0), 1'b0);
    drain("drain_new_id");
    check("drop_count_still_two", 64'(drop_count), 64'd2);

    // 6: FIFO overflow while uart_tx is held busy
    do_reset();
    hold_busy = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(2'd3, 8'd1, 8'd122, 8'd1, MG, 1'b1));
    exp_q.push_back(mk(2'd3, 8'd1, 8'd0, 8'd0, MG, 1'b1));
    exp_q.push_back(mk(2'd3, 8'd1, 8'd5, 8'd0, MG, 1'b1));
    send(mk(2'd3, 8'd1, 8'd122, 8'hFF, MG, 1'b0), 1'b0);
    send(mk(2'd3, 8'd1, 8'd0, 8'hFF, MG, 1'b0), 1'b0);
    send(mk(2'd3, 8'd1, 8'd5, 8'hFF, MG, 1'b0), 1'b0);
    send(mk(2'd3, 8'd1, 8'd9, 8'hFF, MG, 1'b0), 1'b0);
    repeat (10) @(negedge clk);
    check("overflow_drop_count", 64'(drop_count), 64'd1);
    check("overflow_one_sent", 64'(exp_q.size()), 64'd2);
    hold_busy = 1'b0;
    drain("drain_overflow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
